// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers with byte strobes.
// Read and write paths are independent; out-of-range accesses answer SLVERR.
module axi_lite_slave_regs #(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     awvalid_i,
    output logic                     awready_o,
    input  logic [ADDR_W-1:0]        awaddr_i,
    input  logic [2:0]               awprot_i,
    input  logic                     wvalid_i,
    output logic                     wready_o,
    input  logic [31:0]              wdata_i,
    input  logic [3:0]               wstrb_i,
    output logic                     bvalid_o,
    input  logic                     bready_i,
    output logic [1:0]               bresp_o,
    input  logic                     arvalid_i,
    output logic                     arready_o,
    input  logic [ADDR_W-1:0]        araddr_i,
    input  logic [2:0]               arprot_i,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic [31:0]              rdata_o,
    output logic [1:0]               rresp_o,
    output logic [NUM_REGS*32-1:0]   reg_dout_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
        return |a[ADDR_W-1:IDX_W+2];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    logic [0:0]        w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              w_held_q, w_held_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [31:0]       regs_q [NUM_REGS];
    logic [31:0]       regs_d [NUM_REGS];

    logic [0:0]        r_state_q, r_state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              aw_hs, w_hs, ar_hs;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;

    assign awready_o = !rst && !aw_held_q && (w_state_q == W_IDLE);
    assign wready_o  = !rst && !w_held_q && (w_state_q == W_IDLE);
    assign arready_o = !rst && (r_state_q == R_IDLE);

    assign aw_hs = awvalid_i && awready_o;
    assign w_hs  = wvalid_i && wready_o;
    assign ar_hs = arvalid_i && arready_o;

    // A channel that handshook earlier supplies its latched payload; otherwise the live bus does.
    assign wr_addr = aw_held_q ? awaddr_q : awaddr_i;
    assign wr_data = w_held_q ? wdata_q : wdata_i;
    assign wr_strb = w_held_q ? wstrb_q : wstrb_i;

    assign bvalid_o = (w_state_q == W_RESP);
    assign bresp_o  = bresp_q;
    assign rvalid_o = (r_state_q == R_DATA);
    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        if (w_state_q == W_IDLE) begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = awaddr_i;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = wdata_i;
                wstrb_d  = wstrb_i;
            end
            if ((aw_hs || aw_held_q) && (w_hs || w_held_q)) begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                w_state_d = W_RESP;
                if (addr_oor(wr_addr)) begin
                    bresp_d = RESP_SLVERR;
                end else begin
                    bresp_d = RESP_OKAY;
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            regs_d[addr_idx(wr_addr)][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end else if (bready_i) begin
            w_state_d = W_IDLE;
        end
    end

    // Reads sample regs_q, so a same-edge write is not yet visible.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (r_state_q == R_IDLE) begin
            if (ar_hs) begin
                r_state_d = R_DATA;
                if (addr_oor(araddr_i)) begin
                    rdata_d = 32'h0;
                    rresp_d = RESP_SLVERR;
                end else begin
                    rdata_d = regs_q[addr_idx(araddr_i)];
                    rresp_d = RESP_OKAY;
                end
            end
        end else if (rready_i) begin
            r_state_d = R_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_dout
        assign reg_dout_o[32*k +: 32] = regs_q[k];
    end

    logic unused_ok;
    assign unused_ok = ^{awprot_i, arprot_i, wr_addr[1:0], araddr_i[1:0]};

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Bench for axi_lite_slave_regs: reset and corner-case sequences, a vector table,
// and randomized traffic compared against an array-based register model.
module tb_axi_lite_slave_regs;
    localparam int ADDR_W   = 32;
    localparam int NUM_REGS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              awvalid = 1'b0, awready;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [2:0]        awprot = '0;
    logic              wvalid = 1'b0, wready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              bvalid, bready = 1'b0;
    logic [1:0]        bresp;
    logic              arvalid = 1'b0, arready;
    logic [ADDR_W-1:0] araddr = '0;
    logic [2:0]        arprot = '0;
    logic              rvalid, rready = 1'b0;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic [NUM_REGS*32-1:0] reg_dout;

    axi_lite_slave_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awprot_i(awprot),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
        .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
        .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arprot_i(arprot),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
        .reg_dout_o(reg_dout)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NUM_REGS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
        if (a < NUM_REGS * 4) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        if (a < NUM_REGS * 4) begin
            d = model[a / 4];
            resp = 2'b00;
        end else begin
            d = 32'h0;
            resp = 2'b10;
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < NUM_REGS; k++) model[k] = 32'h0;
    endtask

    // Write with independent AW/W start delays (in cycles); BREADY held high.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hit, w_hit;
        int c = 0;
        int lat = 0;
        bready = 1'b1;
        @(negedge clk);
        while (!(aw_done && w_done) && c < 50) begin
            awvalid = (c >= awd) && !aw_done;
            awaddr  = a;
            wvalid  = (c >= wd) && !w_done;
            wdata   = d;
            wstrb   = s;
            #1;
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            @(negedge clk);
            c++;
            if (aw_hit) aw_done = 1;
            if (w_hit) w_done = 1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            errors++;
            $display("FAIL write_handshake_timeout: got aw=%0d w=%0d, expected both done", aw_done, w_done);
        end
        while (!bvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bvalid) begin
            errors++;
            $display("FAIL bvalid_timeout: got bvalid=0, expected 1");
        end
        resp = bresp;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit hit = 0;
        int c = 0;
        rready = 1'b1;
        @(negedge clk);
        while (!hit && c < 50) begin
            arvalid = 1'b1;
            araddr  = a;
            #1;
            hit = arready;
            @(negedge clk);
            c++;
        end
        arvalid = 1'b0;
        if (!hit) begin
            errors++;
            $display("FAIL ar_timeout: got arready=0, expected 1");
        end
        c = 0;
        while (!rvalid && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!rvalid) begin
            errors++;
            $display("FAIL rvalid_timeout: got rvalid=0, expected 1");
        end
        d = rdata;
        resp = rresp;
        @(negedge clk);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [1:0]  resp, mresp;
        logic [31:0] d, md;

        vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h0000_0005, 32'h000000AA, 4'h1, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0007, 32'h0,        4'h0, 2'b00, 32'hDEADBEAA};
        vecs[4]  = '{1'b1, 32'h0000_0040, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'h12345678, 4'h0, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 2'b00, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_000C, 32'hA5A5A5A5, 4'hA, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_000C, 32'h0,        4'h0, 2'b00, 32'hA500A500};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'h00000001, 4'hF, 2'b10, 32'h0};

        // Reset behaviour
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("awready_in_rst", awready, 0);
        chk("wready_in_rst", wready, 0);
        chk("arready_in_rst", arready, 0);
        chk("bvalid_in_rst", bvalid, 0);
        chk("rvalid_in_rst", rvalid, 0);
        chk("rdata_in_rst", rdata, 0);
        chk("regs_in_rst", reg_dout, 0);
        rst = 1'b0;
        #1;
        chk("awready_after_rst", awready, 1);
        chk("wready_after_rst", wready, 1);
        chk("arready_after_rst", arready, 1);

        // AW and W in the same cycle: response and register one cycle later
        @(negedge clk);
        bready = 1'b1;
        awvalid = 1'b1; awaddr = 32'h4;
        wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        #1;
        chk("same_cycle_ready", {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("same_cycle_bvalid", bvalid, 1);
        chk("same_cycle_bresp", bresp, 2'b00);
        chk("same_cycle_reg1", reg_dout[63:32], 32'hDEADBEEF);
        @(negedge clk);
        chk("bvalid_cleared", bvalid, 0);

        // W first, AW three cycles later
        wvalid = 1'b1; wdata = 32'h000000AA; wstrb = 4'b0001;
        #1;
        chk("w_first_wready", wready, 1);
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("w_held_wready", wready, 0);
            chk("w_held_awready", awready, 1);
            chk("w_held_no_bvalid", bvalid, 0);
            @(negedge clk);
        end
        awvalid = 1'b1; awaddr = 32'h4;
        #1;
        chk("late_aw_ready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        chk("late_aw_bvalid", bvalid, 1);
        chk("late_aw_bresp", bresp, 2'b00);
        chk("late_aw_reg1", reg_dout[63:32], 32'hDEADBEAA);
        @(negedge clk);

        // Read stall: RDATA held while RREADY low
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h4;
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_rvalid", rvalid, 1);
            chk("stall_rdata", rdata, 32'hDEADBEAA);
            chk("stall_rresp", rresp, 2'b00);
            chk("stall_arready", arready, 0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        chk("stall_rvalid_cleared", rvalid, 0);
        chk("stall_arready_back", arready, 1);

        // Concurrent write and read of the same register returns the old value
        awvalid = 1'b1; awaddr = 32'h8;
        wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h8;
        #1;
        chk("concurrent_readies", {awready, wready, arready}, 3'b111);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("concurrent_rvalid", rvalid, 1);
        chk("concurrent_rdata_old", rdata, 32'h0);
        chk("concurrent_bvalid", bvalid, 1);
        chk("concurrent_reg2", reg_dout[95:64], 32'h12345678);
        @(negedge clk);
        do_read(32'h8, d, resp);
        chk("reread_reg2", d, 32'h12345678);

        // Reset abandons a held write address
        awvalid = 1'b1; awaddr = 32'hC;
        #1;
        chk("abandon_awready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abandon_awready_after_rst", awready, 1);
        chk("abandon_regs_cleared", reg_dout, 0);
        wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        @(negedge clk);
        wvalid = 1'b0;
        chk("abandon_no_bvalid", bvalid, 0);
        chk("abandon_reg3", reg_dout[127:96], 32'h0);
        chk("abandon_awready_waiting", awready, 1);
        @(negedge clk);
        chk("abandon_no_bvalid_later", bvalid, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_clear();

        // Vector table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, (i + 1) % 3, resp);
                m_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mresp);
                chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, d, resp);
                chk($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            end
        end
        for (int k = 0; k < NUM_REGS; k++)
            chk($sformatf("vec_reg%0d", k), reg_dout[32*k +: 32], model[k]);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, wd;
            logic [3:0]  s;
            a  = $urandom_range(0, 23);
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            awprot = 3'($urandom);
            arprot = 3'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), resp);
                m_write(a, wd, s, mresp);
                chk($sformatf("rand%0d_bresp", i), resp, mresp);
            end else begin
                do_read(a, d, resp);
                m_read(a, md, mresp);
                chk($sformatf("rand%0d_rresp", i), resp, mresp);
                chk($sformatf("rand%0d_rdata", i), d, md);
            end
        end
        for (int k = 0; k < NUM_REGS; k++)
            chk($sformatf("final_reg%0d", k), reg_dout[32*k +: 32], model[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
